// File: rtl/alu_result_stage.sv
// Result FIFO behind alu_core: valid/ready buffering of result/flags/opcode,
// plus a sticky overflow flag and a saturating overflow-event counter.
module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_result,
    input  logic                     in_zero,
    input  logic                     in_overflow,
    input  logic [3:0]               in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic                     out_zero,
    output logic                     out_overflow,
    output logic [3:0]               out_op,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     sticky_ovf,
    output logic [15:0]              ovf_count,
    input  logic                     clr_status
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = WIDTH + 6;

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          r_sticky;
    logic [15:0]   r_count;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_head;

    // Handshakes depend only on registered occupancy, never on in_valid/out_ready.
    assign w_full  = (r_level == LW'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_push  = in_valid && !w_full;
    assign w_pop   = !w_empty && out_ready;

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign level     = r_level;
    assign sticky_ovf = r_sticky;
    assign ovf_count  = r_count;

    // Storage is never reset; the empty mask below hides stale entries.
    assign w_head = w_empty ? '0 : r_mem[r_rptr];
    assign {out_op, out_overflow, out_zero, out_result} = w_head;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= {in_op, in_overflow, in_zero, in_result};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop)
                r_level <= r_level + LW'(1);
            else if (w_pop && !w_push)
                r_level <= r_level - LW'(1);
        end
    end

    // An overflow push in the same cycle as a clear wins: counter restarts at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
            r_count  <= '0;
        end else if (w_push && in_overflow) begin
            r_sticky <= 1'b1;
            if (clr_status)
                r_count <= 16'd1;
            else if (r_count != 16'hFFFF)
                r_count <= r_count + 16'd1;
        end else if (clr_status) begin
            r_sticky <= 1'b0;
            r_count  <= '0;
        end
    end
endmodule
